// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit -- instruction-fetch front end
//
// Issues one instruction-memory read per PC value and keeps up to DEPTH
// in-order fetches in a circular queue. Completed entries are offered to
// IF_ID with valid/stall flow control. A branch redirect (flush) empties the
// queue and counts the reads still owed by memory so their responses are
// thrown away when they eventually arrive.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   pc_in             current PC from the PC register
//   fetch_stall       1 = hold the PC (no request accepted this cycle)
//   flush             redirect from EX, discards every older fetch
//   id_stall          IF_ID cannot accept the head entry this cycle
//   imem_req_*        read request channel (valid/ready, address)
//   imem_rsp_*        read response channel (in request order, data, fault)
//   if_valid          head entry complete and offered to IF_ID
//   if_pc/instr/err   fields of the head entry
// ============================================================================
module fetch_unit #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic            fetch_stall,
    input  logic            flush,
    input  logic            id_stall,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_instr,
    output logic            if_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    // Queue storage and per-entry completion flags
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [ILEN-1:0] q_instr [DEPTH];
    logic [DEPTH-1:0] q_err;
    logic [DEPTH-1:0] q_done;

    // head: oldest entry; tail: next free slot; rsp_ptr: oldest entry still
    // waiting for its response. Responses arrive in order, so the not-done
    // entries always form the contiguous range [rsp_ptr, tail).
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] rsp_ptr;
    logic [CW-1:0] count;     // allocated entries
    logic [CW-1:0] pend_cnt;  // allocated entries with done=0
    logic [CW-1:0] drop_cnt;  // abandoned reads still owed by memory

    logic          req_fire;
    logic          pop;
    logic          rsp_take;
    logic          rsp_drop;
    logic [CW:0]   outstanding;
    logic [CW-1:0] owed;
    logic [CW-1:0] flush_drop;

    assign outstanding = {1'b0, count} + {1'b0, drop_cnt};

    assign imem_req_valid = ~rst & ~flush & (outstanding < DEPTH_W);
    assign imem_req_addr  = pc_in;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // The flush cycle releases the PC so it can load the redirect target.
    assign fetch_stall = rst | (~req_fire & ~flush);

    assign if_valid = ~rst & ~flush & (count != '0) & q_done[head];
    assign pop      = if_valid & ~id_stall;

    // Abandoned reads are retired first; only then does a response belong to
    // a live entry. A response with nothing owed is ignored.
    assign rsp_drop = ~rst & ~flush & imem_rsp_valid & (drop_cnt != '0);
    assign rsp_take = ~rst & ~flush & imem_rsp_valid & (drop_cnt == '0)
                    & (pend_cnt != '0);

    // On flush every not-yet-answered read joins the drop count; a response in
    // the flush cycle belongs to the old stream and retires one of them.
    assign owed       = drop_cnt + pend_cnt;
    assign flush_drop = owed - CW'(imem_rsp_valid && (owed != '0));

    assign if_pc    = rst ? '0 : q_pc[head];
    assign if_instr = rst ? '0 : q_instr[head];
    assign if_err   = rst ? 1'b0 : q_err[head];

    // Control state: pointers, counters and completion flags
    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            rsp_ptr  <= '0;
            count    <= '0;
            pend_cnt <= '0;
            drop_cnt <= '0;
            q_done   <= '0;
        end else if (flush) begin
            head     <= tail;
            rsp_ptr  <= tail;
            count    <= '0;
            pend_cnt <= '0;
            drop_cnt <= flush_drop;
            q_done   <= '0;
        end else begin
            if (req_fire) begin
                tail         <= tail + 1'b1;
                q_done[tail] <= 1'b0;
            end
            if (rsp_take) begin
                q_done[rsp_ptr] <= 1'b1;
                rsp_ptr         <= rsp_ptr + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            count    <= count + CW'(req_fire) - CW'(pop);
            pend_cnt <= pend_cnt + CW'(req_fire) - CW'(rsp_take);
        end
    end

    // NOTE: payload storage is deliberately not reset; q_done and count
    // qualify every read, so stale contents are never presented as valid.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            q_pc[tail] <= pc_in;
        end
        if (rsp_take) begin
            q_instr[rsp_ptr] <= imem_rsp_data;
            q_err[rsp_ptr]   <= imem_rsp_err;
        end
    end

`ifndef SYNTHESIS
    // A response with no live entry and no abandoned read is a memory
    // protocol violation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && pend_cnt == '0 && drop_cnt == '0))
                else $error("fetch_unit: imem response with nothing outstanding");
        end
    end
`endif

endmodule
